fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage. Holds the program counter and issues one instruction read at a time to the instruction memory port. Packs each returned word with its PC into a fetch-to-decode packet and hands it to the decode stage over the fetch-to-decode bus. Sits directly upstream of the fetch-to-decode bus and obeys its busy/send protocol. Accepts branch redirects from execute, which squash any in-flight or held instruction.

## Interface
- ADDR_WIDTH, 32: PC and memory address width.
- INSN_WIDTH, 32: instruction word width.
- RESET_PC, 0: PC loaded on reset; low 2 bits must be zero.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req_valid  out  1  read request valid.
- mem_req_addr  out  ADDR_WIDTH  read address (current PC).
- mem_req_ready  in  1  memory accepts request this cycle.
- mem_resp_valid  in  1  read data valid (one per accepted request, ≥1 cycle after acceptance).
- mem_resp_data  in  INSN_WIDTH  instruction word.
- redirect_valid  in  1  execute-stage redirect, single-cycle pulse.
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored and treated as 0.
- f2d_is_busy  in  1  bus holds an unconsumed packet.
- f2d_send  out  1  one-cycle send strobe; bus latches packet and sets busy.
- f2d_pc  out  ADDR_WIDTH  packet PC, valid while f2d_send=1.
- f2d_insn  out  INSN_WIDTH  packet instruction, valid while f2d_send=1.
- fetch_count  out  32  number of packets sent; wraps modulo 2^32.

## Operation
- At most one outstanding memory request.
- States: REQ, WAIT, SEND, DRAIN.
- REQ: mem_req_valid=1, mem_req_addr=pc. On valid&ready, go to WAIT.
- WAIT: on mem_resp_valid, register data into insn_q and go to SEND.
- SEND: when f2d_is_busy=0, drive f2d_send=1 with f2d_pc=pc and f2d_insn=insn_q. Increment fetch_count. Set pc=pc+4 and go to REQ. While busy, hold all state.
- DRAIN: discard the next mem_resp_valid, then go to REQ. Its data must never reach decode.
- PC arithmetic is modulo 2^ADDR_WIDTH, so 0xFFFF_FFFC+4 = 0x0000_0000.
- A redirect sets pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00} in every state. It has priority over all other events that cycle. Next state:
  - REQ with no handshake: stay in REQ.
  - REQ with a same-cycle accepted handshake: go to DRAIN.
  - WAIT without a response: go to DRAIN.
  - WAIT with a same-cycle response: drop the response, go to REQ.
  - SEND: drop the held packet, f2d_send=0, go to REQ.
  - DRAIN without a response: stay in DRAIN.
  - DRAIN with a same-cycle response: go to REQ.
- f2d_send is never asserted in the same cycle as redirect_valid.
- f2d_send is never asserted while f2d_is_busy=1. Violating this is a protocol error (assertion in the bench).

## Timing
- Reset values:
  - state=REQ, pc=RESET_PC, fetch_count=0.
  - mem_req_valid=0 during the reset cycle, then 1 on the first cycle after reset.
  - f2d_send=0; f2d_pc=0 and f2d_insn=0 while not sending.
- Reset mid-operation abandons any outstanding request. The memory must also be reset, so no stale response arrives after reset.
- Best-case throughput: one packet per 3 cycles (REQ→WAIT→SEND), with ready=1, 1-cycle response latency and bus idle.
- Redirect-to-request latency: mem_req_addr = redirect target on the cycle after redirect_valid. The exception is DRAIN, which waits for the stale response first.
- mem_req_valid is combinational from state only (state==REQ); it does not depend on mem_req_ready.
- f2d_send, f2d_pc and f2d_insn are combinational from state, pc, insn_q, f2d_is_busy and redirect_valid.

## Test plan
- Reset and streaming: RESET_PC=0x100, ready=1, 1-cycle response, bus idle. Expect sends with PC 0x100, 0x104, 0x108 every 3 cycles and fetch_count=3.
- Backpressure: hold f2d_is_busy=1 for 5 cycles while in SEND. Expect no send, no new mem request, and pc/insn stable. The send happens on the first cycle busy=0.
- Redirect in WAIT: request to 0x200 accepted, then redirect to 0x403 before the response. Expect the response for 0x200 discarded. Next request addr=0x400 issued the cycle after that response, and the first packet has PC 0x400.
- Redirect in SEND: packet for 0x300 held with bus busy, then redirect to 0x500. Expect 0x300 never sent and next request addr=0x500.
- Wrap-around: RESET_PC=0xFFFF_FFFC. Expect the first packet PC 0xFFFF_FFFC and the second 0x0000_0000.
- Reset mid-WAIT: assert reset for 1 cycle. Expect state REQ at RESET_PC, fetch_count=0 and f2d_send=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps the PC, issues one instruction read at a time,
// and hands {pc, insn} packets to decode over the busy/send fetch-to-decode bus.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INSN_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [INSN_WIDTH-1:0] mem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  f2d_is_busy,
    output logic                  f2d_send,
    output logic [ADDR_WIDTH-1:0] f2d_pc,
    output logic [INSN_WIDTH-1:0] f2d_insn,
    output logic [31:0]           fetch_count
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_SEND,
        S_DRAIN
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   pc, pc_nxt;
    logic [INSN_WIDTH-1:0]   insn_q, insn_nxt;
    logic [ADDR_WIDTH-1:0]   redir_tgt;
    logic                    req_fire;

    // Redirect targets are word aligned; the low two bits are forced to zero.
    assign redir_tgt = redirect_pc & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    // Reset gating keeps the request and send strobes quiet during the reset cycle.
    assign mem_req_valid = (state == S_REQ) && !reset;
    assign mem_req_addr  = pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign f2d_send = (state == S_SEND) && !f2d_is_busy && !redirect_valid && !reset;
    assign f2d_pc   = f2d_send ? pc     : '0;
    assign f2d_insn = f2d_send ? insn_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            insn_q      <= '0;
            fetch_count <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            insn_q <= insn_nxt;
            if (f2d_send)
                fetch_count <= fetch_count + 32'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        insn_nxt  = insn_q;
        case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_nxt    = redir_tgt;
                    // An accepted request still owes a response that must be dropped.
                    state_nxt = req_fire ? S_DRAIN : S_REQ;
                end else if (req_fire) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt    = redir_tgt;
                    state_nxt = mem_resp_valid ? S_REQ : S_DRAIN;
                end else if (mem_resp_valid) begin
                    insn_nxt  = mem_resp_data;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (redirect_valid) begin
                    pc_nxt    = redir_tgt;
                    state_nxt = S_REQ;
                end else if (!f2d_is_busy) begin
                    pc_nxt    = pc + ADDR_WIDTH'(4);
                    state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect_valid)
                    pc_nxt = redir_tgt;
                if (mem_resp_valid)
                    state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table for the main instance, plus a
// free-running instance at RESET_PC=0xFFFF_FFFC for PC wrap-around.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        f2d_is_busy, f2d_send;
    logic [31:0] f2d_pc, f2d_insn, fetch_count;

    // wrap-around instance signals
    logic        w_req_valid, w_resp_valid, w_send;
    logic [31:0] w_req_addr, w_resp_data, w_pc, w_insn, w_cnt;
    logic [31:0] w_pcs[$];
    logic [31:0] w_insns[$];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_WIDTH(32), .INSN_WIDTH(32), .RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .f2d_is_busy(f2d_is_busy), .f2d_send(f2d_send), .f2d_pc(f2d_pc), .f2d_insn(f2d_insn),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.ADDR_WIDTH(32), .INSN_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset),
        .mem_req_valid(w_req_valid), .mem_req_addr(w_req_addr), .mem_req_ready(1'b1),
        .mem_resp_valid(w_resp_valid), .mem_resp_data(w_resp_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .f2d_is_busy(1'b0), .f2d_send(w_send), .f2d_pc(w_pc), .f2d_insn(w_insn),
        .fetch_count(w_cnt)
    );

    // Always-ready memory with 1-cycle latency; data is the inverted address.
    always @(posedge clk) begin
        if (reset) begin
            w_resp_valid <= 1'b0;
            w_resp_data  <= '0;
        end else begin
            w_resp_valid <= w_req_valid;
            w_resp_data  <= ~w_req_addr;
        end
    end

    always @(negedge clk) begin
        if (w_send === 1'b1) begin
            w_pcs.push_back(w_pc);
            w_insns.push_back(w_insn);
        end
    end

    typedef struct {
        logic        rdy, rv;
        logic [31:0] rd;
        logic        redir;
        logic [31:0] rpc;
        logic        busy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_send;
        logic [31:0] e_pc, e_insn, e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rd, logic redir, logic [31:0] rpc,
                                logic busy, logic e_req, logic [31:0] e_addr, logic e_send,
                                logic [31:0] e_pc, logic [31:0] e_insn, logic [31:0] e_cnt);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.redir = redir; v.rpc = rpc; v.busy = busy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_send = e_send;
        v.e_pc = e_pc; v.e_insn = e_insn; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic redir, input logic [31:0] rpc, input logic busy);
        mem_req_ready  = rdy;
        mem_resp_valid = rv;
        mem_resp_data  = rd;
        redirect_valid = redir;
        redirect_pc    = rpc;
        f2d_is_busy    = busy;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        //        rdy rv rd            rdr rpc           bsy | req addr          snd pc            insn          cnt
        // streaming from RESET_PC, one packet per 3 cycles
        vq.push_back(mk(1, 0, 0,            0, 0,            0,  1, 32'h100, 0, 0,       0,            0));
        vq.push_back(mk(0, 1, 32'hA000_0000,0, 0,            0,  0, 32'h100, 0, 0,       0,            0));
        vq.push_back(mk(0, 0, 0,            0, 0,            0,  0, 32'h100, 1, 32'h100, 32'hA000_0000,0));
        vq.push_back(mk(1, 0, 0,            0, 0,            0,  1, 32'h104, 0, 0,       0,            1));
        vq.push_back(mk(0, 1, 32'hA000_0001,0, 0,            0,  0, 32'h104, 0, 0,       0,            1));
        vq.push_back(mk(0, 0, 0,            0, 0,            0,  0, 32'h104, 1, 32'h104, 32'hA000_0001,1));
        vq.push_back(mk(1, 0, 0,            0, 0,            0,  1, 32'h108, 0, 0,       0,            2));
        vq.push_back(mk(0, 1, 32'hA000_0002,0, 0,            0,  0, 32'h108, 0, 0,       0,            2));
        vq.push_back(mk(0, 0, 0,            0, 0,            0,  0, 32'h108, 1, 32'h108, 32'hA000_0002,2));
        // memory stall, response delay, then 5 cycles of bus backpressure
        vq.push_back(mk(0, 0, 0,            0, 0,            0,  1, 32'h10C, 0, 0,       0,            3));
        vq.push_back(mk(1, 0, 0,            0, 0,            0,  1, 32'h10C, 0, 0,       0,            3));
        vq.push_back(mk(0, 0, 0,            0, 0,            0,  0, 32'h10C, 0, 0,       0,            3));
        vq.push_back(mk(0, 1, 32'hB000_0000,0, 0,            0,  0, 32'h10C, 0, 0,       0,            3));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(0, 0, 0,        0, 0,            1,  0, 32'h10C, 0, 0,       0,            3));
        vq.push_back(mk(0, 0, 0,            0, 0,            0,  0, 32'h10C, 1, 32'h10C, 32'hB000_0000,3));
        // redirect in REQ without handshake, then redirect in WAIT (drain stale 0x200)
        vq.push_back(mk(0, 0, 0,            1, 32'h200,      0,  1, 32'h110, 0, 0,       0,            4));
        vq.push_back(mk(1, 0, 0,            0, 0,            0,  1, 32'h200, 0, 0,       0,            4));
        vq.push_back(mk(0, 0, 0,            1, 32'h403,      0,  0, 32'h200, 0, 0,       0,            4));
        vq.push_back(mk(0, 0, 0,            0, 0,            0,  0, 32'h400, 0, 0,       0,            4));
        vq.push_back(mk(0, 1, 32'hDEAD_BEEF,0, 0,            0,  0, 32'h400, 0, 0,       0,            4));
        vq.push_back(mk(1, 0, 0,            0, 0,            0,  1, 32'h400, 0, 0,       0,            4));
        vq.push_back(mk(0, 1, 32'hC000_0000,0, 0,            0,  0, 32'h400, 0, 0,       0,            4));
        vq.push_back(mk(0, 0, 0,            0, 0,            0,  0, 32'h400, 1, 32'h400, 32'hC000_0000,4));
        // redirect with same-cycle accepted handshake -> drain
        vq.push_back(mk(1, 0, 0,            1, 32'h300,      0,  1, 32'h404, 0, 0,       0,            5));
        vq.push_back(mk(0, 1, 32'hBAD0_0000,0, 0,            0,  0, 32'h300, 0, 0,       0,            5));
        vq.push_back(mk(1, 0, 0,            0, 0,            0,  1, 32'h300, 0, 0,       0,            5));
        vq.push_back(mk(0, 1, 32'hD000_0000,0, 0,            0,  0, 32'h300, 0, 0,       0,            5));
        // 0x300 held under busy, then redirect to 0x500 as the bus frees: never sent
        vq.push_back(mk(0, 0, 0,            0, 0,            1,  0, 32'h300, 0, 0,       0,            5));
        vq.push_back(mk(0, 0, 0,            1, 32'h500,      0,  0, 32'h300, 0, 0,       0,            5));
        vq.push_back(mk(1, 0, 0,            0, 0,            0,  1, 32'h500, 0, 0,       0,            5));
        // redirect in WAIT with same-cycle response: response dropped, straight to REQ
        vq.push_back(mk(0, 1, 32'hE000_0000,1, 32'h600,      0,  0, 32'h500, 0, 0,       0,            5));
        vq.push_back(mk(1, 0, 0,            0, 0,            0,  1, 32'h600, 0, 0,       0,            5));
        vq.push_back(mk(0, 1, 32'hF000_0000,0, 0,            0,  0, 32'h600, 0, 0,       0,            5));
        vq.push_back(mk(0, 0, 0,            0, 0,            0,  0, 32'h600, 1, 32'h600, 32'hF000_0000,5));
        vq.push_back(mk(1, 0, 0,            0, 0,            0,  1, 32'h604, 0, 0,       0,            6));

        // reset cycle outputs
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 0);
        chk("rst_send", 32'(f2d_send), 0);
        chk("rst_f2d_pc", f2d_pc, 0);
        chk("rst_f2d_insn", f2d_insn, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            reset = 1'b0;
            drive(vq[i].rdy, vq[i].rv, vq[i].rd, vq[i].redir, vq[i].rpc, vq[i].busy);
            #1;
            chk($sformatf("c%0d_req_valid", i), 32'(mem_req_valid), 32'(vq[i].e_req));
            chk($sformatf("c%0d_req_addr", i), mem_req_addr, vq[i].e_addr);
            chk($sformatf("c%0d_send", i), 32'(f2d_send), 32'(vq[i].e_send));
            chk($sformatf("c%0d_f2d_pc", i), f2d_pc, vq[i].e_pc);
            chk($sformatf("c%0d_f2d_insn", i), f2d_insn, vq[i].e_insn);
            chk($sformatf("c%0d_fetch_count", i), fetch_count, vq[i].e_cnt);
            chk($sformatf("c%0d_send_protocol", i),
                32'(f2d_send && (f2d_is_busy || redirect_valid)), 0);
        end

        // reset while in WAIT (last vector left the request accepted)
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("midrst_req_valid", 32'(mem_req_valid), 0);
        chk("midrst_send", 32'(f2d_send), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("postrst_req_valid", 32'(mem_req_valid), 1);
        chk("postrst_req_addr", mem_req_addr, 32'h100);
        chk("postrst_fetch_count", fetch_count, 0);
        chk("postrst_send", 32'(f2d_send), 0);

        // wrap-around instance: first two packets straddle 2^32
        n_chk++;
        if (w_pcs.size() < 2) begin
            n_fail++;
            $display("FAIL wrap_packets: got %0d packets, expected at least 2", w_pcs.size());
        end else begin
            chk("wrap_pc0", w_pcs[0], 32'hFFFF_FFFC);
            chk("wrap_insn0", w_insns[0], 32'h0000_0003);
            chk("wrap_pc1", w_pcs[1], 32'h0000_0000);
            chk("wrap_insn1", w_insns[1], 32'hFFFF_FFFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
